// File: rtl/xnor_popcount_accum_pkg.sv
// Shared defaults, FSM state type and sizing helper for the XNOR-popcount
// binarized accumulator.
package xnor_popcount_accum_pkg;

    localparam int LANES_DEFAULT = 32;
    localparam int WIDTH_DEFAULT = 16;
    localparam int ACC_W_DEFAULT = 11;
    localparam int BATCH_W       = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Bits needed to hold a popcount in the range 0..width.
    function automatic int pop_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/xnor_popcount_lane.sv
// Stage 1 of one lane: XNOR activation against weight, count matching bits,
// and register the count together with a valid flag.
module xnor_popcount_lane
    import xnor_popcount_accum_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int POP_W = pop_width(WIDTH_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             accept,
    input  logic [WIDTH-1:0] activation,
    input  logic [WIDTH-1:0] weight,
    output logic [POP_W-1:0] pop,
    output logic             pop_valid
);

    logic [WIDTH-1:0] match;
    logic [POP_W-1:0] pop_next;

    always_comb begin
        match    = ~(activation ^ weight);
        pop_next = '0;
        for (int b = 0; b < WIDTH; b++) begin
            pop_next = pop_next + POP_W'(match[b]);
        end
    end

    // The valid flag only ever lasts one cycle per accepted beat, so the
    // accumulator downstream sees each beat exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop       <= '0;
            pop_valid <= 1'b0;
        end else if (clear) begin
            pop       <= '0;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= accept;
            if (accept) begin
                pop <= pop_next;
            end
        end
    end

endmodule

// File: rtl/xnor_popcount_accum.sv
// Multi-lane binarized dot-product engine: per-lane XNOR-popcount accumulation
// over a batch of beats, then a threshold compare producing one bit per lane.
module xnor_popcount_accum
    import xnor_popcount_accum_pkg::*;
#(
    parameter int LANES = LANES_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BATCH_W-1:0]     batch,
    input  logic [ACC_W-1:0]       threshold,
    input  logic [LANES*WIDTH-1:0] activation_in,
    input  logic [LANES-1:0]       activation_in_valid,
    input  logic [LANES*WIDTH-1:0] weight_in,
    output logic                   busy,
    output logic [LANES-1:0]       result,
    output logic                   result_valid
);

    localparam int POP_W = pop_width(WIDTH);

    state_t             state;
    state_t             state_next;
    logic               load;
    logic               finish_go;
    logic               first_cycle;
    logic [BATCH_W-1:0] batch_q;
    logic [ACC_W-1:0]   threshold_q;
    logic [LANES-1:0]   accept;
    logic [LANES-1:0]   lane_done;
    logic [LANES-1:0]   lane_pending;
    logic [LANES-1:0]   lane_hit;

    assign busy = (state != IDLE);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [BATCH_W-1:0] cnt;
        logic [ACC_W-1:0]   acc;
        logic [POP_W-1:0]   pop;
        logic               pop_valid;

        assign accept[i]       = (state == ACCUM) && activation_in_valid[i] && (cnt < batch_q);
        assign lane_done[i]    = (cnt == batch_q);
        assign lane_pending[i] = pop_valid;
        assign lane_hit[i]     = (acc >= threshold_q);

        xnor_popcount_lane #(
            .WIDTH (WIDTH),
            .POP_W (POP_W)
        ) u_stage1 (
            .clk        (clk),
            .rst        (rst),
            .clear      (load),
            .accept     (accept[i]),
            .activation (activation_in[i*WIDTH +: WIDTH]),
            .weight     (weight_in[i*WIDTH +: WIDTH]),
            .pop        (pop),
            .pop_valid  (pop_valid)
        );

        // Stage 2: beat counter and running sum, both wiped when a job is loaded.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                acc <= '0;
            end else if (load) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                if (accept[i]) begin
                    cnt <= cnt + BATCH_W'(1);
                end
                if (pop_valid) begin
                    acc <= acc + ACC_W'(pop);
                end
            end
        end
    end

    // The completion check is held off for the first ACCUM cycle so that an
    // empty batch still takes two clocks from start to result, matching the
    // two-clock tail that follows the last beat of a non-empty batch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish_go  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (!first_cycle && (&lane_done) && !(|lane_pending)) begin
                    finish_go  = 1'b1;
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The result is captured on the edge that enters FINISH, so the FINISH
    // cycle is exactly the cycle in which result_valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            batch_q      <= '0;
            threshold_q  <= '0;
            first_cycle  <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_next;
            first_cycle  <= load;
            result_valid <= finish_go;
            if (load) begin
                batch_q     <= batch;
                threshold_q <= threshold;
            end
            if (finish_go) begin
                result <= lane_hit;
            end
        end
    end

endmodule

// File: tb/tb_xnor_popcount_accum.sv
// Randomized self-checking bench: a per-lane count/sum model decides the
// expected result bits and the cycle in which result_valid must appear.
module tb_xnor_popcount_accum;

    localparam int L  = 32;
    localparam int W  = 16;
    localparam int AW = 11;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [5:0]     batch;
    logic [AW-1:0]  threshold;
    logic [L*W-1:0] activation_in;
    logic [L-1:0]   activation_in_valid;
    logic [L*W-1:0] weight_in;
    logic           busy;
    logic [L-1:0]   result;
    logic           result_valid;

    int assert_count = 0;
    int fail_count   = 0;

    xnor_popcount_accum dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .batch               (batch),
        .threshold           (threshold),
        .activation_in       (activation_in),
        .activation_in_valid (activation_in_valid),
        .weight_in           (weight_in),
        .busy                (busy),
        .result              (result),
        .result_valid        (result_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // pattern 1: a = w, pattern 2: a = ~w, otherwise independent random data
    task automatic driveLanes(input int pattern, input logic [L-1:0] want);
        logic [W-1:0] a;
        logic [W-1:0] w;
        for (int i = 0; i < L; i++) begin
            w = W'($urandom);
            if (pattern == 1)      a = w;
            else if (pattern == 2) a = ~w;
            else                   a = W'($urandom);
            activation_in[i*W +: W] = a;
            weight_in[i*W +: W]     = w;
        end
        activation_in_valid = want;
    endtask

    // pattern 3 is the staggered case: lane 31 holds off for ten cycles.
    // extra3 sends that many surplus beats on lane 3; restart re-pulses start.
    task automatic applyStimulus(input string name, input int b, input int thr, input int pattern,
                                 input int extra3, input bit restart);
        int           sent[L];
        int           mcnt[L];
        int           msum[L];
        int           edge_n;
        int           last_acc;
        int           pulse_edge;
        int           pulses;
        int           limit;
        logic [L-1:0] want;
        logic [L-1:0] exp_res;
        logic [L-1:0] res_at_pulse;
        logic [W-1:0] match;

        repeat (2) begin
            @(negedge clk);
            driveLanes(0, L'($urandom));
        end
        @(negedge clk);
        activation_in_valid = '0;
        start     = 1'b1;
        batch     = b[5:0];
        threshold = thr[AW-1:0];
        for (int i = 0; i < L; i++) begin
            sent[i] = 0;
            mcnt[i] = 0;
            msum[i] = 0;
        end
        @(posedge clk);
        #1;
        checkOutput({name, " busy_after_start"}, 64'(busy), 64'd1);

        edge_n       = 0;
        last_acc     = 0;
        pulse_edge   = -1;
        pulses       = 0;
        res_at_pulse = '0;
        while (edge_n < 600 && !(pulse_edge >= 0 && edge_n >= pulse_edge + 3)) begin
            @(negedge clk);
            start = restart && (edge_n == 1);
            if (start) begin
                batch     = 6'd7;
                threshold = '0;
            end
            for (int i = 0; i < L; i++) begin
                limit = b + ((i == 3) ? extra3 : 0);
                if (sent[i] >= limit)  want[i] = 1'b0;
                else if (pattern == 3) want[i] = (edge_n >= ((i == L - 1) ? 10 : 0));
                else if (pattern == 0) want[i] = 1'($urandom_range(0, 1));
                else                   want[i] = 1'b1;
            end
            driveLanes((pattern == 3) ? 0 : pattern, want);
            @(posedge clk);
            edge_n++;
            for (int i = 0; i < L; i++) begin
                if (activation_in_valid[i]) begin
                    sent[i]++;
                    if (mcnt[i] < b) begin
                        mcnt[i]++;
                        match   = ~(activation_in[i*W +: W] ^ weight_in[i*W +: W]);
                        msum[i] += $countones(match);
                        last_acc = edge_n;
                    end
                end
            end
            #1;
            if (result_valid) begin
                pulses++;
                if (pulse_edge < 0) begin
                    pulse_edge   = edge_n;
                    res_at_pulse = result;
                end
            end
        end
        activation_in_valid = '0;
        start = 1'b0;

        for (int i = 0; i < L; i++) begin
            exp_res[i] = (msum[i] >= thr);
        end
        if (pulse_edge < 0) begin
            checkOutput({name, " timeout"}, 64'd0, 64'd1);
        end else begin
            checkOutput({name, " latency"}, 64'(pulse_edge - last_acc), 64'd2);
        end
        checkOutput({name, " pulse_count"}, 64'(pulses), 64'd1);
        checkOutput({name, " result"}, 64'(res_at_pulse), 64'(exp_res));
        checkOutput({name, " result_hold"}, 64'(result), 64'(exp_res));
        checkOutput({name, " busy_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst                 = 1'b1;
        start               = 1'b0;
        batch               = '0;
        threshold           = '0;
        activation_in       = '0;
        weight_in           = '0;
        activation_in_valid = '0;
        #12;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset result", 64'(result), 64'd0);
        checkOutput("reset result_valid", 64'(result_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("match_b1", 1, 16, 1, 0, 1'b0);
        checkOutput("match_b1 all_ones", 64'(result), 64'hFFFF_FFFF);
        applyStimulus("mismatch_b4", 4, 1, 2, 0, 1'b0);
        checkOutput("mismatch_b4 all_zero", 64'(result), 64'h0);
        applyStimulus("stagger_b4", 4, 34, 3, 0, 1'b0);
        applyStimulus("empty_thr0", 0, 0, 0, 0, 1'b0);
        checkOutput("empty_thr0 all_ones", 64'(result), 64'hFFFF_FFFF);
        applyStimulus("empty_thr5", 0, 5, 0, 0, 1'b0);
        checkOutput("empty_thr5 all_zero", 64'(result), 64'h0);
        applyStimulus("restart_b2", 2, 16, 0, 3, 1'b1);
        for (int j = 0; j < 5; j++) begin
            int rb;
            rb = $urandom_range(1, 63);
            applyStimulus($sformatf("random%0d", j), rb, $urandom_range(0, rb * 16), 0, 0, 1'b0);
        end

        applyStimulus("pre_reset", 1, 16, 1, 0, 1'b0);
        @(negedge clk);
        start     = 1'b1;
        batch     = 6'd4;
        threshold = 11'd1;
        @(negedge clk);
        start = 1'b0;
        driveLanes(1, '1);
        @(negedge clk);
        driveLanes(1, '1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midjob_reset busy", 64'(busy), 64'd0);
        checkOutput("midjob_reset result", 64'(result), 64'd0);
        checkOutput("midjob_reset result_valid", 64'(result_valid), 64'd0);
        activation_in_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("post_reset", 1, 16, 1, 0, 1'b0);
        checkOutput("post_reset all_ones", 64'(result), 64'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
